// File: rtl/pipeline_pkg.sv
// Shared defaults for the compute-stage pipeline blocks (valid tracker, result sinks).
package pipeline_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;
endpackage

// File: rtl/pipeline_result_sink_if.sv
// Issue/ack/result handshake between issuer, pipeline tail and downstream consumer.
interface pipeline_result_sink_if
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH) + 1
);
    logic              issue;
    logic              can_issue;
    logic              ack;
    logic [DATA_W-1:0] ack_data;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  count;
    logic              idle;
    logic              overflow;

    modport master (
        output issue, ack, ack_data, ready,
        input  can_issue, valid, data, count, idle, overflow
    );

    modport slave (
        input  issue, ack, ack_data, ready,
        output can_issue, valid, data, count, idle, overflow
    );
endinterface

// File: rtl/pipeline_result_sink_sync_fifo.sv
// Show-ahead synchronous FIFO; a write while full is accepted only when a read frees a slot.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_drop,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              valid_reg;
    logic              full_reg;
    logic              do_wr;
    logic              do_rd;

    assign do_rd   = rd_en && valid_reg;
    assign do_wr   = wr_en && (!full_reg || do_rd);
    assign wr_drop = wr_en && !do_wr;

    always_comb begin
        count_next = count_reg;
        if (do_wr && !do_rd) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!do_wr && do_rd) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Flags are registered from count_next so no read-side input reaches them combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            full_reg   <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            valid_reg <= (count_next != '0);
            full_reg  <= (count_next == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data  = mem[rd_ptr_reg];
    assign rd_valid = valid_reg;
    assign count    = count_reg;
endmodule

// File: rtl/pipeline_result_sink.sv
// Pipeline tail: buffers acked results, returns issue credits so acks always find a free slot.
module pipeline_result_sink
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_result_sink_if.slave  bus
);
    logic [CNT_W-1:0]  credits_reg;
    logic [CNT_W-1:0]  credits_next;
    logic              can_issue_reg;
    logic              idle_reg;
    logic              overflow_reg;
    logic              issue_ok;
    logic              pop;
    logic              credit_ret;
    logic              wr_drop;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_valid;
    logic [CNT_W-1:0]  fifo_count;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (bus.ack),
        .wr_data  (bus.ack_data),
        .rd_en    (bus.ready),
        .rd_data  (fifo_data),
        .rd_valid (fifo_valid),
        .wr_drop  (wr_drop),
        .count    (fifo_count)
    );

    assign pop      = fifo_valid && bus.ready;
    assign issue_ok = bus.issue && (credits_reg != '0);
    // A pop with all credits home can only follow a rogue ack; never count past DEPTH.
    assign credit_ret = pop && (credits_reg != CNT_W'(DEPTH));

    always_comb begin
        credits_next = credits_reg;
        if (issue_ok && !credit_ret) begin
            credits_next = credits_reg - CNT_W'(1);
        end else if (!issue_ok && credit_ret) begin
            credits_next = credits_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_reg   <= CNT_W'(DEPTH);
            can_issue_reg <= 1'b1;
            idle_reg      <= 1'b1;
            overflow_reg  <= 1'b0;
        end else begin
            credits_reg   <= credits_next;
            can_issue_reg <= (credits_next != '0);
            idle_reg      <= (credits_next == CNT_W'(DEPTH));
            if (wr_drop) overflow_reg <= 1'b1;
        end
    end

    assign bus.can_issue = can_issue_reg;
    assign bus.idle      = idle_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.valid     = fifo_valid;
    assign bus.data      = fifo_data;
    assign bus.count     = fifo_count;
endmodule

// File: tb/tb_pipeline_result_sink.sv
// Bench for pipeline_result_sink: directed vector table plus a queue scoreboard fed by a latency model.
module tb_pipeline_result_sink;
    import pipeline_pkg::*;

    localparam int DATA_W = DATA_W_DEF;
    localparam int DEPTH  = DEPTH_DEF;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int LAT    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_result_sink_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    pipeline_result_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit                issue;
        bit                ack;
        logic [DATA_W-1:0] ack_data;
        bit                ready;
        bit                e_valid;
        logic [DATA_W-1:0] e_data;
        bit                e_can;
        bit                e_idle;
        int                e_count;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    int                credits_m;
    logic [DATA_W-1:0] q_m[$];
    bit                ovf_m;
    bit                pipe_v[LAT];
    logic [DATA_W-1:0] pipe_d[LAT];
    int                seq;
    bit                credit_chk  = 1'b1;
    bit                inflight_chk = 1'b1;
    int                accepted_dut;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        credits_m = DEPTH;
        q_m.delete();
        ovf_m = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            pipe_v[k] = 1'b0;
            pipe_d[k] = '0;
        end
    endtask

    task automatic compare_outputs();
        if (credit_chk) begin
            check("can_issue", bus.can_issue, credits_m != 0);
            check("idle", bus.idle, credits_m == DEPTH);
        end
        check("valid", bus.valid, q_m.size() != 0);
        check("count", bus.count, q_m.size());
        check("overflow", bus.overflow, ovf_m);
        if (q_m.size() != 0) check("head_data", bus.data, q_m[0]);
    endtask

    // Called at posedge+1: compare, drive this cycle's inputs, advance model, step one clock.
    task automatic sb_cycle(input bit issue, input bit ready, input bit force_ack,
                            input logic [DATA_W-1:0] force_data);
        bit                acc;
        bit                ack;
        bit                pop;
        bit                ret;
        logic [DATA_W-1:0] ad;
        compare_outputs();
        acc = issue && (credits_m != 0);
        ack = force_ack ? 1'b1 : pipe_v[LAT-1];
        ad  = force_ack ? force_data : pipe_d[LAT-1];
        pop = (q_m.size() != 0) && ready;
        if (issue && bus.can_issue) accepted_dut++;
        if (bus.valid && ready) $display("pop data=%08h count=%0d t=%0t", bus.data, bus.count, $time);
        bus.issue    = issue;
        bus.ready    = ready;
        bus.ack      = ack;
        bus.ack_data = ad;
        for (int k = LAT - 1; k > 0; k--) begin
            pipe_v[k] = pipe_v[k-1];
            pipe_d[k] = pipe_d[k-1];
        end
        pipe_v[0] = acc;
        pipe_d[0] = DATA_W'(seq);
        if (acc) seq++;
        if (pop) void'(q_m.pop_front());
        if (ack) begin
            if (q_m.size() < DEPTH) q_m.push_back(ad);
            else ovf_m = 1'b1;
        end
        ret = pop && (credits_m < DEPTH);
        if (acc && !ret) credits_m--;
        else if (!acc && ret) credits_m++;
        @(posedge clk);
        #1;
    endtask

    // In-flight operations (DEPTH - credits - count) must never go negative.
    always @(negedge clk) begin
        if (rst_n && inflight_chk) begin
            checks++;
            if (DEPTH - int'(dut.credits_reg) - int'(bus.count) < 0) begin
                errors++;
                $display("FAIL inflight_nonneg: credits=%0d count=%0d t=%0t",
                         dut.credits_reg, bus.count, $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[9];
        int   idx;
        int   first;
        int   last;
        int   n;
        bit   can_low;

        tbl[0] = '{1, 0, '0,           0, 0, '0,           1, 1, 0};
        tbl[1] = '{0, 0, '0,           0, 0, '0,           1, 0, 0};
        tbl[2] = '{0, 0, '0,           0, 0, '0,           1, 0, 0};
        tbl[3] = '{0, 0, '0,           0, 0, '0,           1, 0, 0};
        tbl[4] = '{0, 0, '0,           0, 0, '0,           1, 0, 0};
        tbl[5] = '{0, 1, 32'hDEADBEEF, 0, 0, '0,           1, 0, 0};
        tbl[6] = '{0, 0, '0,           1, 1, 32'hDEADBEEF, 1, 0, 1};
        tbl[7] = '{0, 0, '0,           0, 0, '0,           1, 1, 0};
        tbl[8] = '{0, 0, '0,           0, 0, '0,           1, 1, 0};

        bus.issue = 1'b0; bus.ready = 1'b0; bus.ack = 1'b0; bus.ack_data = '0;
        seq = 0; accepted_dut = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset then idle
        repeat (10) sb_cycle(0, 0, 0, '0);

        // single op from the vector table
        for (int i = 0; i < 9; i++) begin
            check($sformatf("vec%0d_can_issue", i), bus.can_issue, tbl[i].e_can);
            check($sformatf("vec%0d_idle", i), bus.idle, tbl[i].e_idle);
            check($sformatf("vec%0d_valid", i), bus.valid, tbl[i].e_valid);
            check($sformatf("vec%0d_count", i), bus.count, tbl[i].e_count);
            if (tbl[i].e_valid) check($sformatf("vec%0d_data", i), bus.data, tbl[i].e_data);
            bus.issue = tbl[i].issue; bus.ack = tbl[i].ack;
            bus.ack_data = tbl[i].ack_data; bus.ready = tbl[i].ready;
            @(posedge clk);
            #1;
        end
        model_reset();

        // back-pressure: issue every cycle with ready low
        seq = 0; accepted_dut = 0;
        repeat (20) sb_cycle(1, 0, 0, '0);
        check("bp_accepted", accepted_dut, DEPTH);
        check("bp_count", bus.count, DEPTH);
        check("bp_can_issue", bus.can_issue, 0);
        check("bp_overflow", bus.overflow, 0);
        idx = 0;
        repeat (12) begin
            if (bus.valid) begin
                check("bp_order", bus.data, idx);
                idx++;
            end
            sb_cycle(0, 1, 0, '0);
        end
        check("bp_drained", idx, DEPTH);

        // full throughput
        seq = 0; first = -1; last = -1; n = 0; can_low = 1'b0;
        for (int c = 0; c < 110; c++) begin
            if (bus.valid) begin
                check("tp_order", bus.data, n);
                if (first < 0) first = c;
                last = c;
                n++;
            end
            if (c < 100 && !bus.can_issue) can_low = 1'b1;
            sb_cycle(c < 100, 1, 0, '0);
        end
        check("tp_results", n, 100);
        check("tp_first_latency", first, LAT + 1);
        check("tp_one_per_cycle", last - first, 99);
        check("tp_can_issue_held", can_low, 0);

        // simultaneous ack and pop at full, then ack while full without pop
        seq = 0;
        repeat (15) sb_cycle(1, 0, 0, '0);
        check("full_count", bus.count, DEPTH);
        credit_chk = 1'b0; inflight_chk = 1'b0;
        sb_cycle(0, 1, 1, 32'hA5A50001);
        check("sim_count", bus.count, DEPTH);
        check("sim_overflow", bus.overflow, 0);
        check("sim_head", bus.data, 1);
        sb_cycle(0, 0, 1, 32'hBAD00BAD);
        check("ovf_set", bus.overflow, 1);
        check("ovf_count", bus.count, DEPTH);
        repeat (3) sb_cycle(0, 0, 0, '0);
        repeat (10) sb_cycle(0, 1, 0, '0);
        check("ovf_sticky", bus.overflow, 1);
        check("ovf_drained", bus.count, 0);

        // clean restart, then async reset mid-burst
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        credit_chk = 1'b1; inflight_chk = 1'b1; seq = 0;
        repeat (10) sb_cycle(1, 0, 0, '0);
        check("pre_rst_idle", bus.idle, 0);
        check("pre_rst_count", bus.count, 5);
        #2 rst_n = 1'b0;
        bus.issue = 1'b0; bus.ready = 1'b0; bus.ack = 1'b0; bus.ack_data = '0;
        #1;
        check("arst_can_issue", bus.can_issue, 1);
        check("arst_idle", bus.idle, 1);
        check("arst_valid", bus.valid, 0);
        check("arst_count", bus.count, 0);
        check("arst_overflow", bus.overflow, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (5) sb_cycle(0, 0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_result_sink.md
# pipeline_result_sink

Receive-side companion to the fixed-latency pipeline valid tracker. It captures result data on each pipeline ack, buffers results in a small FIFO and presents them downstream over valid/ready. It returns issue credits to the issuer so the non-stallable pipeline can never deliver a result with nowhere to land. It sits at the tail of each GPU compute stage, between the stage datapath and the next stage or writeback.

## Interface
- DATA_W, 32: result width in bits.
- DEPTH, 8: FIFO entries and initial credits; power of two, ≥ 2. Full throughput requires DEPTH ≥ stage valid-chain length + 2 (default chain of 5 → 7, so 8).
- CNT_W, $clog2(DEPTH)+1: width of counters and of o_count.

- i_clk  in  1  single clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_issue  in  1  issuer starts one operation this cycle; same net as the valid tracker's enable.
- o_can_issue  out  1  at least one credit available; registered.
- i_ack  in  1  pipeline result valid this cycle; the valid tracker's ack output.
- i_data  in  DATA_W  result data, sampled when i_ack = 1.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  downstream accepts o_data when o_valid = 1.
- o_data  out  DATA_W  head-of-FIFO result.
- o_count  out  CNT_W  entries currently stored.
- o_idle  out  1  no credits outstanding: FIFO empty and nothing in flight.
- o_overflow  out  1  sticky error; i_ack arrived while the FIFO was full.

## Operation
- Reset values: credits = DEPTH; FIFO empty; o_can_issue = 1; o_valid = 0; o_count = 0; o_idle = 1; o_overflow = 0; o_data = don't-care.
- Credits:
  - Accepted issue: i_issue && credits != 0. It decrements credits.
  - Pop: o_valid && i_ready. It increments credits.
  - Accepted issue and pop in the same cycle: credits unchanged.
  - i_issue while credits == 0 is an issuer protocol violation. It is ignored: no decrement. The bench flags it as an assertion.
- FIFO:
  - Write: i_ack. It stores i_data at wr_ptr; wr_ptr and count advance.
  - Read: pop. rd_ptr advances and count decrements.
  - Simultaneous write and read are legal, including when full. The read frees the slot and count is unchanged.
  - Pointers wrap modulo DEPTH.
- Overflow: i_ack with count == DEPTH and no pop in the same cycle.
  - The data is dropped and no pointer moves.
  - o_overflow sets and stays set until reset.
  - This is unreachable when issuers respect o_can_issue.
- o_idle = (credits == DEPTH).
- In-flight operations = DEPTH − credits − count. This value is never negative; the bench asserts it.
- Reset mid-operation: all state clears immediately. Acks still arriving from the pipeline after release are the responsibility of the shared reset, which also clears the valid tracker.

## Timing
- o_valid, o_count, o_can_issue and o_idle are all registered, derived from state flops.
- o_data is a show-ahead read of mem[rd_ptr].
- Ack to output: i_ack in cycle t on an empty FIFO gives o_valid = 1 and o_data = that data in cycle t+1.
- End-to-end: issue in cycle t, tracker ack in cycle t+L, o_valid in cycle t+L+1, where L is the tracker chain length.
- Credit return: a pop in cycle t raises o_can_issue in cycle t+1 if credits were 0.
- Credit exhaustion: the issue consuming the last credit in cycle t drops o_can_issue in cycle t+1.
- No combinational path from i_ready to o_can_issue or o_valid.

## Structure
- Sub-module sync_fifo: DATA_W, DEPTH, show-ahead, count output, write-when-full-with-read allowed.
  - The credit counter and overflow flag live in pipeline_result_sink.
- Shared package pipeline_pkg: default DATA_W and default DEPTH, reused by the valid tracker and other stages. No typedefs needed.

## Test plan
- Reset, then idle: o_can_issue = 1, o_idle = 1, o_valid = 0, o_count = 0 with no stimulus for 10 cycles.
- Single op: issue at cycle 0; ack with 0xDEADBEEF at cycle 5.
  - Required: o_valid = 1 and o_data = 0xDEADBEEF at cycle 6.
  - i_ready = 1 there gives o_idle = 1 at cycle 7.
- Back-pressure, DEPTH = 8, i_ready = 0: issue every cycle.
  - Required: exactly 8 issues accepted and o_can_issue = 0.
  - o_count reaches 8 and o_overflow stays 0.
  - Releasing i_ready drains 8 results in issue order: data = issue index 0..7.
- Full throughput, i_ready = 1, issue every cycle for 100 cycles.
  - Required: o_can_issue never drops.
  - 100 results arrive in order, one per cycle, after the fixed latency.
- Simultaneous ack and pop at count = 8: count stays 8, o_overflow = 0, the correct head is presented next cycle.
- Forced ack while full with no pop: o_overflow = 1 and stays set; FIFO contents unchanged. Async reset mid-burst clears all outputs to their reset values without waiting for a clock edge.
